// File: rtl/reorder_buffer_pkg.sv
// Shared constants and helpers for the reorder buffer.
// ROB_SIZE and the field widths are defined here and imported by reorder_buffer.
package reorder_buffer_pkg;

    localparam int ROB_SIZE    = 16;
    localparam int ROB_POS_WID = 4;   // index into the circular buffer
    localparam int ROB_ID_WID  = 5;   // one extra bit so the count can reach ROB_SIZE
    localparam int REG_POS_WID = 5;
    localparam int DATA_WID    = 32;
    localparam int ADDR_WID    = 32;

    // Restart address after a mispredicted branch retires.
    function automatic logic [ADDR_WID-1:0] redirect_pc(
        input logic                real_jump,
        input logic [ADDR_WID-1:0] target,
        input logic [ADDR_WID-1:0] pc
    );
        return real_jump ? target : pc + ADDR_WID'(4);
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// 16-entry reorder buffer: in-order issue, out-of-order result writeback,
// in-order commit with branch-mispredict rollback.
// Optional macro ROB_BYPASS_EN: operand queries see a same-cycle result.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    // decoder issue
    input  logic                   issue,
    input  logic [REG_POS_WID-1:0] issue_rd,
    input  logic [ADDR_WID-1:0]    issue_pc,
    input  logic                   issue_is_branch,
    input  logic                   issue_pred_jump,
    output logic [ROB_POS_WID-1:0] issue_rob_pos,
    output logic                   rob_full,
    // execution results
    input  logic                   result,
    input  logic [ROB_POS_WID-1:0] result_rob_pos,
    input  logic [DATA_WID-1:0]    result_val,
    input  logic                   result_jump,
    input  logic [ADDR_WID-1:0]    result_pc,
    // operand queries
    input  logic [ROB_POS_WID-1:0] query_rs1_pos,
    output logic                   query_rs1_ready,
    output logic [DATA_WID-1:0]    query_rs1_val,
    input  logic [ROB_POS_WID-1:0] query_rs2_pos,
    output logic                   query_rs2_ready,
    output logic [DATA_WID-1:0]    query_rs2_val,
    // commit toward the register file
    output logic                   rob_commit,
    output logic [REG_POS_WID-1:0] rob_commit_rd,
    output logic [DATA_WID-1:0]    rob_commit_val,
    output logic [ROB_POS_WID-1:0] rob_commit_rob_pos,
    // rollback
    output logic                   rollback,
    output logic [ADDR_WID-1:0]    rollback_pc
);

    // entry storage
    logic                   busy_q      [ROB_SIZE];
    logic                   busy_d      [ROB_SIZE];
    logic                   ready_q     [ROB_SIZE];
    logic                   ready_d     [ROB_SIZE];
    logic [REG_POS_WID-1:0] rd_q        [ROB_SIZE];
    logic [REG_POS_WID-1:0] rd_d        [ROB_SIZE];
    logic [DATA_WID-1:0]    val_q       [ROB_SIZE];
    logic [DATA_WID-1:0]    val_d       [ROB_SIZE];
    logic [ADDR_WID-1:0]    pc_q        [ROB_SIZE];
    logic [ADDR_WID-1:0]    pc_d        [ROB_SIZE];
    logic                   is_branch_q [ROB_SIZE];
    logic                   is_branch_d [ROB_SIZE];
    logic                   pred_jump_q [ROB_SIZE];
    logic                   pred_jump_d [ROB_SIZE];
    logic                   real_jump_q [ROB_SIZE];
    logic                   real_jump_d [ROB_SIZE];
    logic [ADDR_WID-1:0]    target_q    [ROB_SIZE];
    logic [ADDR_WID-1:0]    target_d    [ROB_SIZE];

    // pointers and registered outputs
    logic [ROB_POS_WID-1:0] head_q, head_d;
    logic [ROB_POS_WID-1:0] tail_q, tail_d;
    logic [ROB_ID_WID-1:0]  count_q, count_d;
    logic                   rob_commit_q, rob_commit_d;
    logic [REG_POS_WID-1:0] commit_rd_q, commit_rd_d;
    logic [DATA_WID-1:0]    commit_val_q, commit_val_d;
    logic [ROB_POS_WID-1:0] commit_pos_q, commit_pos_d;
    logic                   rollback_q, rollback_d;
    logic [ADDR_WID-1:0]    rollback_pc_q, rollback_pc_d;

    // Nothing moves while stalled or during the cycle a rollback is being signalled.
    logic active;
    logic do_issue;
    logic do_result;
    logic do_commit;
    logic mispredict;

    assign active     = rdy && !rollback_q;
    assign do_issue   = active && issue && (count_q != ROB_ID_WID'(ROB_SIZE));
    assign do_result  = active && result && busy_q[result_rob_pos];
    assign do_commit  = active && busy_q[head_q] && ready_q[head_q];
    assign mispredict = do_commit && is_branch_q[head_q]
                        && (real_jump_q[head_q] != pred_jump_q[head_q]);

    assign issue_rob_pos      = tail_q;
    assign rob_full           = count_q >= ROB_ID_WID'(ROB_SIZE - 1);
    assign rob_commit         = rob_commit_q;
    assign rob_commit_rd      = commit_rd_q;
    assign rob_commit_val     = commit_val_q;
    assign rob_commit_rob_pos = commit_pos_q;
    assign rollback           = rollback_q;
    assign rollback_pc        = rollback_pc_q;

    // Next-state for entries, pointers and the one-cycle commit/rollback pulses.
    always_comb begin
        busy_d        = busy_q;
        ready_d       = ready_q;
        rd_d          = rd_q;
        val_d         = val_q;
        pc_d          = pc_q;
        is_branch_d   = is_branch_q;
        pred_jump_d   = pred_jump_q;
        real_jump_d   = real_jump_q;
        target_d      = target_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        rob_commit_d  = rob_commit_q;
        commit_rd_d   = commit_rd_q;
        commit_val_d  = commit_val_q;
        commit_pos_d  = commit_pos_q;
        rollback_d    = rollback_q;
        rollback_pc_d = rollback_pc_q;

        if (rdy) begin
            // pulses last one enabled cycle; payload fields hold their last value
            rob_commit_d = 1'b0;
            rollback_d   = 1'b0;

            if (do_result) begin
                ready_d[result_rob_pos]     = 1'b1;
                val_d[result_rob_pos]       = result_val;
                real_jump_d[result_rob_pos] = result_jump;
                target_d[result_rob_pos]    = result_pc;
            end

            if (do_issue) begin
                busy_d[tail_q]      = 1'b1;
                ready_d[tail_q]     = 1'b0;
                rd_d[tail_q]        = issue_rd;
                pc_d[tail_q]        = issue_pc;
                is_branch_d[tail_q] = issue_is_branch;
                pred_jump_d[tail_q] = issue_pred_jump;
                tail_d              = tail_q + ROB_POS_WID'(1);
            end

            if (do_commit) begin
                busy_d[head_q] = 1'b0;
                head_d         = head_q + ROB_POS_WID'(1);
                rob_commit_d   = 1'b1;
                commit_rd_d    = rd_q[head_q];
                commit_val_d   = val_q[head_q];
                commit_pos_d   = head_q;
            end

            count_d = count_q + ROB_ID_WID'(do_issue) - ROB_ID_WID'(do_commit);

            // a wrong-path flush discards everything younger than the branch
            if (mispredict) begin
                rollback_d    = 1'b1;
                rollback_pc_d = redirect_pc(real_jump_q[head_q], target_q[head_q], pc_q[head_q]);
                for (int i = 0; i < ROB_SIZE; i++) begin
                    busy_d[i] = 1'b0;
                end
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end
        end
    end

    // Control state and registered outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROB_SIZE; i++) begin
                busy_q[i]  <= 1'b0;
                ready_q[i] <= 1'b0;
            end
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            rob_commit_q  <= 1'b0;
            commit_rd_q   <= '0;
            commit_val_q  <= '0;
            commit_pos_q  <= '0;
            rollback_q    <= 1'b0;
            rollback_pc_q <= '0;
        end else begin
            busy_q        <= busy_d;
            ready_q       <= ready_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            rob_commit_q  <= rob_commit_d;
            commit_rd_q   <= commit_rd_d;
            commit_val_q  <= commit_val_d;
            commit_pos_q  <= commit_pos_d;
            rollback_q    <= rollback_d;
            rollback_pc_q <= rollback_pc_d;
        end
    end

    // Entry payload; only meaningful while busy, so it carries no reset.
    always_ff @(posedge clk) begin
        rd_q        <= rd_d;
        val_q       <= val_d;
        pc_q        <= pc_d;
        is_branch_q <= is_branch_d;
        pred_jump_q <= pred_jump_d;
        real_jump_q <= real_jump_d;
        target_q    <= target_d;
    end

    // Operand lookup, optionally forwarding a result arriving this cycle.
    always_comb begin
        query_rs1_ready = ready_q[query_rs1_pos];
        query_rs1_val   = val_q[query_rs1_pos];
        query_rs2_ready = ready_q[query_rs2_pos];
        query_rs2_val   = val_q[query_rs2_pos];
`ifdef ROB_BYPASS_EN
        if (result && (result_rob_pos == query_rs1_pos)) begin
            query_rs1_ready = 1'b1;
            query_rs1_val   = result_val;
        end
        if (result && (result_rob_pos == query_rs2_pos)) begin
            query_rs2_ready = 1'b1;
            query_rs2_val   = result_val;
        end
`endif
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Testbench for reorder_buffer: directed scenarios plus randomized traffic,
// checked against an in-order queue model of the buffer.
module tb_reorder_buffer;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        issue;
    logic [4:0]  issue_rd;
    logic [31:0] issue_pc;
    logic        issue_is_branch;
    logic        issue_pred_jump;
    logic [3:0]  issue_rob_pos;
    logic        rob_full;
    logic        result;
    logic [3:0]  result_rob_pos;
    logic [31:0] result_val;
    logic        result_jump;
    logic [31:0] result_pc;
    logic [3:0]  query_rs1_pos;
    logic        query_rs1_ready;
    logic [31:0] query_rs1_val;
    logic [3:0]  query_rs2_pos;
    logic        query_rs2_ready;
    logic [31:0] query_rs2_val;
    logic        rob_commit;
    logic [4:0]  rob_commit_rd;
    logic [31:0] rob_commit_val;
    logic [3:0]  rob_commit_rob_pos;
    logic        rollback;
    logic [31:0] rollback_pc;

    reorder_buffer dut (
        .clk                (clk),
        .rst                (rst),
        .rdy                (rdy),
        .issue              (issue),
        .issue_rd           (issue_rd),
        .issue_pc           (issue_pc),
        .issue_is_branch    (issue_is_branch),
        .issue_pred_jump    (issue_pred_jump),
        .issue_rob_pos      (issue_rob_pos),
        .rob_full           (rob_full),
        .result             (result),
        .result_rob_pos     (result_rob_pos),
        .result_val         (result_val),
        .result_jump        (result_jump),
        .result_pc          (result_pc),
        .query_rs1_pos      (query_rs1_pos),
        .query_rs1_ready    (query_rs1_ready),
        .query_rs1_val      (query_rs1_val),
        .query_rs2_pos      (query_rs2_pos),
        .query_rs2_ready    (query_rs2_ready),
        .query_rs2_val      (query_rs2_val),
        .rob_commit         (rob_commit),
        .rob_commit_rd      (rob_commit_rd),
        .rob_commit_val     (rob_commit_val),
        .rob_commit_rob_pos (rob_commit_rob_pos),
        .rollback           (rollback),
        .rollback_pc        (rollback_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ROB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // ---------------- reference model: program-order queue ----------------
    typedef struct {
        logic [3:0]  pos;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        br;
        logic        pred;
        logic        done;
        logic        rj;
        logic [31:0] val;
        logic [31:0] tgt;
    } ent_t;

    ent_t        ents[$];
    int          m_tail;
    logic        m_commit;
    logic [4:0]  m_crd;
    logic [31:0] m_cval;
    logic [3:0]  m_cpos;
    logic        m_rb;
    logic [31:0] m_rbpc;

    int n_cmp = 0;
    int n_mis = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        ent_t e;
        bit   c;
        bit   mis;
        bit   can_iss;
        bit   prev_rb;
        ent_t n;
        if (rst) begin
            ents.delete();
            m_tail = 0; m_commit = 0; m_crd = 0; m_cval = 0; m_cpos = 0;
            m_rb = 0; m_rbpc = 0;
        end else if (rdy) begin
            prev_rb  = m_rb;
            m_commit = 0;
            m_rb     = 0;
            if (!prev_rb) begin
                c       = (ents.size() > 0) && ents[0].done;
                can_iss = issue && (ents.size() < 16);
                if (c) e = ents[0];
                if (result) begin
                    foreach (ents[i]) begin
                        if (ents[i].pos == result_rob_pos) begin
                            ents[i].done = 1'b1;
                            ents[i].val  = result_val;
                            ents[i].rj   = result_jump;
                            ents[i].tgt  = result_pc;
                        end
                    end
                end
                mis = 0;
                if (c) begin
                    void'(ents.pop_front());
                    m_commit = 1; m_crd = e.rd; m_cval = e.val; m_cpos = e.pos;
                    if (e.br && (e.rj != e.pred)) begin
                        mis    = 1;
                        m_rb   = 1;
                        m_rbpc = e.rj ? e.tgt : e.pc + 32'd4;
                    end
                end
                if (mis) begin
                    ents.delete();
                    m_tail = 0;
                end else if (can_iss) begin
                    n.pos = 4'(m_tail); n.rd = issue_rd; n.pc = issue_pc;
                    n.br = issue_is_branch; n.pred = issue_pred_jump;
                    n.done = 0; n.rj = 0; n.val = 0; n.tgt = 0;
                    ents.push_back(n);
                    m_tail = (m_tail + 1) % 16;
                end
            end
        end
    endtask

    task automatic check_query(input string tag, input logic [3:0] qpos,
                               input logic grdy, input logic [31:0] gval);
        int idx;
        idx = -1;
        if (BYPASS && result && (result_rob_pos == qpos)) begin
            chk({tag, "_byp_rdy"}, 64'(grdy), 64'd1);
            chk({tag, "_byp_val"}, 64'(gval), 64'(result_val));
        end else begin
            foreach (ents[i]) if (ents[i].pos == qpos) idx = i;
            if (idx >= 0) begin
                chk({tag, "_rdy"}, 64'(grdy), 64'(ents[idx].done));
                if (ents[idx].done) chk({tag, "_val"}, 64'(gval), 64'(ents[idx].val));
            end
        end
    endtask

    task automatic check_outputs();
        chk("issue_pos",   64'(issue_rob_pos),      64'(m_tail));
        chk("rob_full",    64'(rob_full),           64'(ents.size() >= 15));
        chk("commit",      64'(rob_commit),         64'(m_commit));
        chk("commit_rd",   64'(rob_commit_rd),      64'(m_crd));
        chk("commit_val",  64'(rob_commit_val),     64'(m_cval));
        chk("commit_pos",  64'(rob_commit_rob_pos), 64'(m_cpos));
        chk("rollback",    64'(rollback),           64'(m_rb));
        chk("rollback_pc", 64'(rollback_pc),        64'(m_rbpc));
        check_query("q1", query_rs1_pos, query_rs1_ready, query_rs1_val);
        check_query("q2", query_rs2_pos, query_rs2_ready, query_rs2_val);
    endtask

    // Inputs are driven at the falling edge; check, then cross one rising edge.
    task automatic tick();
        #1;
        if (chk_en) check_outputs();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; rdy = 1; issue = 0; result = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic set_issue(input logic [4:0] rd, input logic [31:0] pc,
                             input logic br, input logic pred);
        issue = 1; issue_rd = rd; issue_pc = pc; issue_is_branch = br; issue_pred_jump = pred;
    endtask

    task automatic set_result(input logic [3:0] pos, input logic [31:0] v,
                              input logic j, input logic [31:0] t);
        result = 1; result_rob_pos = pos; result_val = v; result_jump = j; result_pc = t;
    endtask

    // Target a random (or the oldest) in-flight entry still waiting for its result.
    task automatic pick_result(input bit oldest);
        int cand[$];
        foreach (ents[i]) if (!ents[i].done) cand.push_back(i);
        if (cand.size() == 0) begin
            result = 0;
        end else begin
            set_result(ents[oldest ? cand[0] : cand[$urandom_range(cand.size() - 1)]].pos,
                       $urandom, 1'($urandom), $urandom);
        end
    endtask

    int ncom;

    initial begin
        rst = 1; rdy = 1; issue = 0; issue_rd = 0; issue_pc = 0;
        issue_is_branch = 0; issue_pred_jump = 0;
        result = 0; result_rob_pos = 0; result_val = 0; result_jump = 0; result_pc = 0;
        query_rs1_pos = 0; query_rs2_pos = 1;
        @(negedge clk);
        tick();
        chk_en = 1'b1;
        do_reset();
        chk("rst_pos",      64'(issue_rob_pos), 64'd0);
        chk("rst_commit",   64'(rob_commit),    64'd0);
        chk("rst_rollback", 64'(rollback),      64'd0);
        chk("rst_full",     64'(rob_full),      64'd0);

        // single issue, result, commit
        idle(); set_issue(5'd5, 32'h0, 0, 0); tick();
        idle(); set_result(4'd0, 32'h1234, 0, 0); tick();
        idle(); tick();
        chk("t1_commit", 64'(rob_commit),         64'd1);
        chk("t1_rd",     64'(rob_commit_rd),      64'd5);
        chk("t1_val",    64'(rob_commit_val),     64'h1234);
        chk("t1_pos",    64'(rob_commit_rob_pos), 64'd0);
        tick();
        chk("t1_pulse_end", 64'(rob_commit), 64'd0);

        // out-of-order results, in-order commits
        do_reset();
        idle(); set_issue(5'd1, 32'h10, 0, 0); tick();
        idle(); set_issue(5'd2, 32'h14, 0, 0); tick();
        idle(); set_result(4'd1, 32'hb, 0, 0); tick();
        idle(); set_result(4'd0, 32'ha, 0, 0); tick();
        idle(); tick();
        chk("t2_first_pos",  64'(rob_commit_rob_pos), 64'd0);
        chk("t2_first_com",  64'(rob_commit),         64'd1);
        tick();
        chk("t2_second_pos", 64'(rob_commit_rob_pos), 64'd1);
        chk("t2_second_val", 64'(rob_commit_val),     64'hb);

        // fill, overflow attempt, drain with wrap
        do_reset();
        for (int i = 0; i < 15; i++) begin
            idle(); set_issue(5'(i), 32'(i * 4), 0, 0); tick();
        end
        chk("t3_full15", 64'(rob_full),      64'd1);
        chk("t3_pos15",  64'(issue_rob_pos), 64'd15);
        idle(); set_issue(5'd15, 32'h3c, 0, 0); tick();
        idle(); set_issue(5'd16, 32'h40, 0, 0); tick();
        chk("t3_ignored", 64'(issue_rob_pos), 64'd0);
        ncom = 0;
        for (int i = 0; i < 40; i++) begin
            idle(); set_issue(5'($urandom), $urandom, 0, 0); pick_result(1'b1); tick();
            if (rob_commit === 1'b1) ncom++;
        end
        chk("t3_commits", 64'(ncom), 64'd39);

        // mispredicted taken branch with younger entries
        do_reset();
        idle(); set_issue(5'd0, 32'h100, 1, 0); tick();
        idle(); set_issue(5'd3, 32'h104, 0, 0); tick();
        idle(); set_issue(5'd4, 32'h108, 0, 0); tick();
        idle(); set_result(4'd0, 32'h0, 1, 32'h200); tick();
        idle(); tick();
        chk("t4_rollback", 64'(rollback),    64'd1);
        chk("t4_rb_pc",    64'(rollback_pc), 64'h200);
        idle(); set_issue(5'd7, 32'h200, 0, 0); set_result(4'd1, 32'h5, 0, 0); tick();
        chk("t4_rb_end",   64'(rollback),      64'd0);
        chk("t4_tail0",    64'(issue_rob_pos), 64'd0);
        idle(); set_issue(5'd7, 32'h200, 0, 0); tick();
        chk("t4_landed",   64'(issue_rob_pos), 64'd1);

        // predicted taken, actually not taken; then a correct prediction
        do_reset();
        idle(); set_issue(5'd0, 32'h100, 1, 1); tick();
        idle(); set_result(4'd0, 32'h0, 0, 32'h300); tick();
        idle(); tick();
        chk("t5_rollback", 64'(rollback),    64'd1);
        chk("t5_rb_pc",    64'(rollback_pc), 64'h104);
        tick();
        idle(); set_issue(5'd0, 32'h100, 1, 1); tick();
        idle(); set_result(4'd0, 32'h0, 1, 32'h300); tick();
        idle(); tick();
        chk("t5_no_rb",    64'(rollback),   64'd0);
        chk("t5_commit",   64'(rob_commit), 64'd1);

        // same-cycle forwarding, then reset in the middle of traffic
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle(); set_issue(5'(i + 1), 32'(i * 4), 0, 0); tick();
        end
        idle(); query_rs1_pos = 4'd3; set_result(4'd3, 32'd7, 0, 0);
        #1;
        chk("t6_byp_rdy", 64'(query_rs1_ready), 64'(BYPASS));
        tick();
        idle(); set_result(4'd0, 32'd9, 0, 0); tick();
        idle(); rst = 1; set_issue(5'd9, 32'h0, 0, 0); tick();
        rst = 0;
        chk("t6_rst_commit", 64'(rob_commit),    64'd0);
        chk("t6_rst_rb",     64'(rollback),      64'd0);
        chk("t6_rst_pos",    64'(issue_rob_pos), 64'd0);
        chk("t6_rst_full",   64'(rob_full),      64'd0);

        // randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            idle();
            rst = ($urandom_range(199) == 0);
            rdy = ($urandom_range(9) != 0);
            if ($urandom_range(9) < 6)
                set_issue(5'($urandom), $urandom & 32'hffff_fffc,
                          ($urandom_range(4) == 0), 1'($urandom));
            if ($urandom_range(9) < 6) begin
                if ($urandom_range(4) != 0) pick_result(1'b0);
                else set_result(4'($urandom), $urandom, 1'($urandom), $urandom);
            end
            query_rs1_pos = 4'($urandom);
            query_rs2_pos = 4'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
